// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// start/busy/done handshake; results held in DONE until the next start.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state;
    logic [DIVIDEND_W-1:0] sh;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  part_rem;
    logic [CNT_W-1:0]      cnt;

    logic [DIVISOR_W:0]    r_shift;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;
    logic [DIVISOR_W-1:0]  r_next;
    logic [DIVIDEND_W-1:0] q_next;

    // part_rem < dvs always, so r_shift < 2*dvs: the borrow bit of the
    // trial subtraction alone decides whether the divisor fits.
    always_comb begin
        r_shift = {part_rem, sh[DIVIDEND_W-1]};
        diff    = r_shift - {1'b0, dvs};
        fits    = ~diff[DIVISOR_W];
        r_next  = fits ? diff[DIVISOR_W-1:0] : r_shift[DIVISOR_W-1:0];
        q_next  = {sh[DIVIDEND_W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            sh          <= '0;
            dvs         <= '0;
            part_rem    <= '0;
            cnt         <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh          <= dividend;
                        dvs         <= divisor;
                        part_rem    <= '0;
                        cnt         <= '0;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    sh       <= q_next;
                    part_rem <= r_next;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: reset, nominal, edge operands,
// divide by zero, handshake abuse, mid-op reset and an exhaustive sweep.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_restoring_divider #(
        .DIVIDEND_W(8),
        .DIVISOR_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses start; edges = clock edges after the accepting one until done
    // (-1 on timeout), bcnt = samples with busy high.
    task automatic run_div(input logic [7:0] n, input logic [3:0] d,
                           output int edges, output int bcnt);
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        tick();
        start = 1'b0;
        edges = 0;
        bcnt  = 0;
        while (!done && edges < 20) begin
            if (busy) bcnt++;
            tick();
            edges++;
        end
        if (!done) edges = -1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        tick();
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got b=%b d=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_nominal;
        int e, b;
        run_div(8'd200, 4'd7, e, b);
        checks++;
        if (e !== 8 || b !== 8) begin
            errors++;
            $display("FAIL nominal_timing got edges=%0d busy=%0d want 8 8", e, b);
        end
        checks++;
        if ({quotient, remainder, div_by_zero, busy} !== {8'd28, 4'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nominal_result got q=%0d r=%0d z=%b b=%b want 28 4 0 0",
                     quotient, remainder, div_by_zero, busy);
        end
    endtask

    task automatic test_edge_operands;
        logic [7:0] n_t [5] = '{8'd255, 8'd0, 8'd15, 8'd14, 8'd255};
        logic [3:0] d_t [5] = '{4'd1, 4'd5, 4'd15, 4'd15, 4'd15};
        logic [7:0] q_t [5] = '{8'd255, 8'd0, 8'd1, 8'd0, 8'd17};
        logic [3:0] r_t [5] = '{4'd0, 4'd0, 4'd0, 4'd14, 4'd0};
        int e, b;
        for (int i = 0; i < 5; i++) begin
            run_div(n_t[i], d_t[i], e, b);
            checks++;
            if (e !== 8 || quotient !== q_t[i] || remainder !== r_t[i]) begin
                errors++;
                $display("FAIL edge_%0d/%0d got e=%0d q=%0d r=%0d want 8 %0d %0d",
                         n_t[i], d_t[i], e, quotient, remainder, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int e, b;
        run_div(8'd9, 4'd0, e, b);
        checks++;
        if (e !== 0 || b !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dz_timing got edges=%0d busy_cnt=%0d busy=%b want 0 0 0",
                     e, b, busy);
        end
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL dz_result got q=%0d r=%0d z=%b want 255 0 1",
                     quotient, remainder, div_by_zero);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({done, busy, quotient, div_by_zero} !== {1'b1, 1'b0, 8'd255, 1'b1}) begin
            errors++;
            $display("FAIL dz_hold got d=%b b=%b q=%0d z=%b want 1 0 255 1",
                     done, busy, quotient, div_by_zero);
        end
        run_div(8'd9, 4'd3, e, b);
        checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd3, 4'd0, 1'b0} || e !== 8) begin
            errors++;
            $display("FAIL dz_clear got e=%0d q=%0d r=%0d z=%b want 8 3 0 0",
                     e, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int e;
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
        tick();
        dividend = 8'd50;
        divisor  = 4'd2;
        e = 0;
        while (!done && e < 20) begin
            tick();
            e++;
        end
        checks++;
        if (e !== 8 || quotient !== 8'd33 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL abuse_first got e=%0d q=%0d r=%0d want 8 33 1",
                     e, quotient, remainder);
        end
        tick();
        checks++;
        if ({done, busy, quotient} !== {1'b0, 1'b1, 8'd33}) begin
            errors++;
            $display("FAIL abuse_accept got d=%b b=%b q=%0d want 0 1 33",
                     done, busy, quotient);
        end
        start = 1'b0;
        e = 0;
        while (!done && e < 20) begin
            tick();
            e++;
        end
        checks++;
        if (e !== 8 || quotient !== 8'd25 || remainder !== 4'd0) begin
            errors++;
            $display("FAIL abuse_second got e=%0d q=%0d r=%0d want 8 25 0",
                     e, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op;
        int e, b;
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            errors++;
            $display("FAIL midrst_outputs got b=%b d=%b q=%0d r=%0d z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_idle got busy=%b done=%b want 0 0", busy, done);
        end
        run_div(8'd37, 4'd6, e, b);
        checks++;
        if (e !== 8 || quotient !== 8'd6 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL midrst_after got e=%0d q=%0d r=%0d want 8 6 1",
                     e, quotient, remainder);
        end
    endtask

    task automatic test_sweep;
        int e, b, shown;
        logic ok;
        shown = 0;
        for (int n = 0; n < 256; n++) begin
            for (int d = 0; d < 16; d++) begin
                run_div(8'(n), 4'(d), e, b);
                if (d == 0)
                    ok = (e == 0) && (quotient === 8'd255) && (remainder === 4'd0)
                         && (div_by_zero === 1'b1);
                else
                    ok = (e == 8) && !$isunknown({quotient, remainder})
                         && (int'(quotient) * d + int'(remainder) == n)
                         && (int'(remainder) < d) && (div_by_zero === 1'b0);
                checks++;
                if (!ok) begin
                    errors++;
                    if (shown < 10)
                        $display("FAIL sweep_%0d/%0d got e=%0d q=%0d r=%0d z=%b",
                                 n, d, e, quotient, remainder, div_by_zero);
                    shown++;
                end
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_nominal();
        test_edge_operands();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
